// File: rtl/plru_multiset.sv
// ---------------------------------------------------------------------------
// plru_multiset
//   Tree pseudo-LRU replacement controller, one tree and one valid bitmap
//   per set. Invalid ways are filled (lowest index first) before the tree
//   is consulted for an eviction victim.
//
// Parameters
//   WAYS  associativity, power of two, >= 2
//   SETS  number of sets, >= 1
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   access_valid    hit: make access_way MRU in access_set
//   access_set/way  hit location
//   victim_req      miss: allocate a way in victim_set
//   victim_set      miss set index
//   flush_valid     invalidate flush_set (tree and valid bits cleared)
//   flush_set       set to invalidate
//   victim_valid    one-cycle pulse, victim_way/victim_err valid
//   victim_way      allocated way (0 on error)
//   victim_err      victim_set was out of range
//   set_full        combinational: all ways of victim_set are valid
//
// Handshake: victim_req sampled at edge N produces exactly one cycle of
// victim_valid after that edge, with the state update committed at the same
// edge. There is no backpressure; the consumer must take the pulse.
// ---------------------------------------------------------------------------
module plru_multiset #(
    parameter  int WAYS  = 16,
    parameter  int SETS  = 4,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             access_valid,
    input  logic [SET_W-1:0] access_set,
    input  logic [WAY_W-1:0] access_way,
    input  logic             victim_req,
    input  logic [SET_W-1:0] victim_set,
    input  logic             flush_valid,
    input  logic [SET_W-1:0] flush_set,
    output logic             victim_valid,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_err,
    output logic             set_full
);

    // Node n has children 2n+1 (left) and 2n+2 (right); a 0 bit means the
    // LRU side is the left subtree.
    logic [WAYS-2:0]  r_tree  [SETS];
    logic [WAYS-1:0]  r_valid [SETS];

    logic             r_victim_valid;
    logic [WAY_W-1:0] r_victim_way;
    logic             r_victim_err;

    logic             w_vic_in_range;
    logic [WAYS-2:0]  w_vic_tree;
    logic [WAYS-1:0]  w_vic_valid_raw;
    logic [WAYS-1:0]  w_vic_valid;
    logic [WAY_W-1:0] w_vic_way;

    logic [WAYS-2:0]  w_tree_nxt  [SETS];
    logic [WAYS-1:0]  w_valid_nxt [SETS];

    // Point every node on the root-to-leaf path away from way.
    function automatic logic [WAYS-2:0] f_touch(input logic [WAYS-2:0] t,
                                                input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] res;
        int              node;
        logic            dir;
        res  = t;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir       = way[WAY_W-1-l];
            res[node] = ~dir;
            node      = 2 * node + 1 + int'(dir);
        end
        return res;
    endfunction

    // Follow the node bits from the root; the leaf reached is the LRU way.
    function automatic logic [WAY_W-1:0] f_walk(input logic [WAYS-2:0] t);
        logic [WAY_W-1:0] way;
        int               node;
        logic             dir;
        way  = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir             = t[node];
            way[WAY_W-1-l]  = dir;
            node            = 2 * node + 1 + int'(dir);
        end
        return way;
    endfunction

    function automatic logic [WAY_W-1:0] f_first_invalid(input logic [WAYS-1:0] v);
        logic [WAY_W-1:0] way;
        way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!v[i]) way = WAY_W'(i);
        end
        return way;
    endfunction

    // Victim selection from the pre-cycle state of victim_set. Indexing is
    // done by comparison so an out-of-range index never reads the arrays.
    always_comb begin
        w_vic_in_range  = 1'b0;
        w_vic_tree      = '0;
        w_vic_valid_raw = '0;
        for (int s = 0; s < SETS; s++) begin
            if (victim_set == SET_W'(s)) begin
                w_vic_in_range  = 1'b1;
                w_vic_tree      = r_tree[s];
                w_vic_valid_raw = r_valid[s];
            end
        end
        // A same-cycle flush of the same set wins: allocate as if empty.
        w_vic_valid = w_vic_valid_raw;
        if (flush_valid && (flush_set == victim_set)) begin
            w_vic_tree  = '0;
            w_vic_valid = '0;
        end
        if (&w_vic_valid) w_vic_way = f_walk(w_vic_tree);
        else              w_vic_way = f_first_invalid(w_vic_valid);
    end

    assign set_full = w_vic_in_range && (&w_vic_valid_raw);

    // Per-set next state: flush beats hit; the victim touch is applied last
    // so it overrides any path nodes shared with a same-cycle hit.
    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            w_tree_nxt[s]  = r_tree[s];
            w_valid_nxt[s] = r_valid[s];
            if (flush_valid && (flush_set == SET_W'(s))) begin
                w_tree_nxt[s]  = '0;
                w_valid_nxt[s] = '0;
            end else if (access_valid && (access_set == SET_W'(s))) begin
                w_tree_nxt[s] = f_touch(w_tree_nxt[s], access_way);
            end
            if (victim_req && (victim_set == SET_W'(s))) begin
                w_tree_nxt[s]             = f_touch(w_tree_nxt[s], w_vic_way);
                w_valid_nxt[s][w_vic_way] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_tree[s]  <= '0;
                r_valid[s] <= '0;
            end
            r_victim_valid <= 1'b0;
            r_victim_way   <= '0;
            r_victim_err   <= 1'b0;
        end else begin
            for (int s = 0; s < SETS; s++) begin
                r_tree[s]  <= w_tree_nxt[s];
                r_valid[s] <= w_valid_nxt[s];
            end
            r_victim_valid <= victim_req;
            r_victim_err   <= victim_req && !w_vic_in_range;
            r_victim_way   <= (victim_req && w_vic_in_range) ? w_vic_way : '0;
        end
    end

    assign victim_valid = r_victim_valid;
    assign victim_way   = r_victim_way;
    assign victim_err   = r_victim_err;

endmodule

// File: tb/tb_plru_multiset.sv
module tb_plru_multiset;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- main instance: WAYS=16, SETS=4 ----------------
    logic       rst = 1'b1;
    logic       access_valid = 1'b0;
    logic [1:0] access_set = '0;
    logic [3:0] access_way = '0;
    logic       victim_req = 1'b0;
    logic [1:0] victim_set = '0;
    logic       flush_valid = 1'b0;
    logic [1:0] flush_set = '0;
    logic       victim_valid;
    logic [3:0] victim_way;
    logic       victim_err;
    logic       set_full;

    logic [4:0] exp_q[$];   // {err, way}

    plru_multiset #(.WAYS(16), .SETS(4)) u_dut (
        .clk(clk), .rst(rst),
        .access_valid(access_valid), .access_set(access_set), .access_way(access_way),
        .victim_req(victim_req), .victim_set(victim_set),
        .flush_valid(flush_valid), .flush_set(flush_set),
        .victim_valid(victim_valid), .victim_way(victim_way),
        .victim_err(victim_err), .set_full(set_full)
    );

    always @(negedge clk) begin : mon_main
        logic [4:0] e;
        if (victim_valid) begin
            if (exp_q.size() == 0) begin
                chk("main_unexpected_victim", 32'(victim_way), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("main_victim", 32'({victim_err, victim_way}), 32'(e));
            end
        end
    end

    // One cycle of stimulus; a victim request queues its expected way.
    task automatic cyc(input logic hv, input logic [1:0] hs, input logic [3:0] hw,
                       input logic vr, input logic [1:0] vs,
                       input logic fv, input logic [1:0] fs, input logic [3:0] ew);
        access_valid = hv; access_set = hs; access_way = hw;
        victim_req   = vr; victim_set = vs;
        flush_valid  = fv; flush_set  = fs;
        if (vr) exp_q.push_back({1'b0, ew});
        tick();
        access_valid = 1'b0;
        victim_req   = 1'b0;
        flush_valid  = 1'b0;
    endtask

    task automatic vreq(input logic [1:0] s, input logic [3:0] ew);
        cyc(1'b0, 2'd0, 4'd0, 1'b1, s, 1'b0, 2'd0, ew);
    endtask

    task automatic hit(input logic [1:0] s, input logic [3:0] w);
        cyc(1'b1, s, w, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic full_chk(input string name, input logic [1:0] s, input logic exp);
        victim_set = s;
        #1;
        chk(name, 32'(set_full), 32'(exp));
    endtask

    // ---------------- parameter sweep: WAYS=2,4,32, SETS=3 ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int W  = (g == 0) ? 2 : (g == 1) ? 4 : 32;
        localparam int WW = $clog2(W);

        logic          s_rst = 1'b1;
        logic          s_av = 1'b0;
        logic [1:0]    s_as = '0;
        logic [WW-1:0] s_aw = '0;
        logic          s_vr = 1'b0;
        logic [1:0]    s_vs = '0;
        logic          s_fv = 1'b0;
        logic [1:0]    s_fs = '0;
        logic          s_vv;
        logic [WW-1:0] s_vw;
        logic          s_ve;
        logic          s_sf;
        logic          done = 1'b0;
        logic [WW:0]   q[$];

        plru_multiset #(.WAYS(W), .SETS(3)) u_dut (
            .clk(clk), .rst(s_rst),
            .access_valid(s_av), .access_set(s_as), .access_way(s_aw),
            .victim_req(s_vr), .victim_set(s_vs),
            .flush_valid(s_fv), .flush_set(s_fs),
            .victim_valid(s_vv), .victim_way(s_vw),
            .victim_err(s_ve), .set_full(s_sf)
        );

        always @(negedge clk) begin : mon_sw
            logic [WW:0] e;
            if (s_vv) begin
                if (q.size() == 0) begin
                    chk($sformatf("sweep%0d_unexpected_victim", W), 32'(s_vw), 32'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("sweep%0d_victim", W), 32'({s_ve, s_vw}), 32'(e));
                end
            end
        end

        task automatic sreq(input logic [1:0] s, input logic err, input logic [WW-1:0] ew);
            s_vr = 1'b1; s_vs = s;
            q.push_back({err, ew});
            tick();
            s_vr = 1'b0;
        endtask

        initial begin
            tick(); tick();
            s_rst = 1'b0;
            chk($sformatf("sweep%0d_reset_valid", W), 32'(s_vv), 32'd0);
            // Cold fill returns 0..W-1.
            for (int i = 0; i < W; i++) sreq(2'd0, 1'b0, WW'(i));
            s_vs = 2'd0;
            #1;
            chk($sformatf("sweep%0d_full", W), 32'(s_sf), 32'd1);
            // Out-of-range set with an out-of-range hit: error, no state change.
            s_av = 1'b1; s_as = 2'd3; s_aw = WW'(1);
            sreq(2'd3, 1'b1, '0);
            s_av = 1'b0;
            sreq(2'd0, 1'b0, '0);
            // Hit to 0 then the victim is the opposite half.
            s_av = 1'b1; s_as = 2'd0; s_aw = '0;
            tick();
            s_av = 1'b0;
            sreq(2'd0, 1'b0, WW'(W / 2));
            // Reset drops an in-flight request and empties the set.
            s_rst = 1'b1; s_vr = 1'b1; s_vs = 2'd0;
            tick();
            s_rst = 1'b0; s_vr = 1'b0;
            chk($sformatf("sweep%0d_reset_drop", W), 32'(s_vv), 32'd0);
            sreq(2'd0, 1'b0, '0);
            tick(); tick();
            chk($sformatf("sweep%0d_queue_empty", W), 32'(q.size()), 32'd0);
            done = 1'b1;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin
        tick(); tick();
        rst = 1'b0;
        chk("reset_victim_valid", 32'(victim_valid), 32'd0);
        chk("reset_victim_way",   32'(victim_way),   32'd0);
        chk("reset_victim_err",   32'(victim_err),   32'd0);
        full_chk("reset_set_full", 2'd2, 1'b0);

        // Cold fill of set 2.
        for (int i = 0; i < 16; i++) vreq(2'd2, 4'(i));
        full_chk("fill_set2_full", 2'd2, 1'b1);
        full_chk("fill_set0_untouched", 2'd0, 1'b0);

        // PLRU walk.
        vreq(2'd2, 4'd0);
        hit(2'd2, 4'd0);
        vreq(2'd2, 4'd8);
        hit(2'd2, 4'd8);
        vreq(2'd2, 4'd4);

        // Simultaneous hit + victim on a freshly filled set 1.
        for (int i = 0; i < 16; i++) vreq(2'd1, 4'(i));
        cyc(1'b1, 2'd1, 4'd0, 1'b1, 2'd1, 1'b0, 2'd0, 4'd0);
        vreq(2'd1, 4'd8);

        // Flush + victim collision on full set 1.
        full_chk("pre_flush_set1_full", 2'd1, 1'b1);
        cyc(1'b0, 2'd0, 4'd0, 1'b1, 2'd1, 1'b1, 2'd1, 4'd0);
        vreq(2'd1, 4'd1);
        full_chk("post_flush_set1_not_full", 2'd1, 1'b0);

        // Independent sets in one cycle: flush set 2, hit set 1, victim set 3.
        cyc(1'b1, 2'd1, 4'd5, 1'b1, 2'd3, 1'b1, 2'd2, 4'd0);
        full_chk("flushed_set2_not_full", 2'd2, 1'b0);
        vreq(2'd2, 4'd0);
        vreq(2'd1, 4'd2);

        // Refill set 2, then reset during an in-flight request.
        for (int i = 1; i < 16; i++) vreq(2'd2, 4'(i));
        full_chk("refill_set2_full", 2'd2, 1'b1);
        rst = 1'b1; victim_req = 1'b1; victim_set = 2'd2;
        tick();
        rst = 1'b0; victim_req = 1'b0;
        chk("reset_drop_valid", 32'(victim_valid), 32'd0);
        full_chk("reset_cleared_set2", 2'd2, 1'b0);
        vreq(2'd2, 4'd0);
        tick(); tick();
        chk("main_queue_empty", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 2000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); i++) tick();
        chk("sweep_done", 32'(g_sw[0].done && g_sw[1].done && g_sw[2].done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/plru_multiset.md
# plru_multiset

Parametrised tree pseudo-LRU replacement controller for the IFU instruction cache. It generalises 16-way single-set PLRU to any power-of-two way count and any number of sets, and holds one tree plus one valid bitmap per set. It fills invalid ways before evicting, and returns a registered victim through a one-cycle request/response handshake. It supports per-set flush, and sits between the cache controller's hit/miss logic and the tag/data array write enables.

## Interface
- WAYS, 16, associativity; power of two, ≥2; WAY_W = $clog2(WAYS)
- SETS, 4, number of sets, ≥1; SET_W = max(1,$clog2(SETS))
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- access_valid  in  1  hit: mark access_way MRU in access_set
- access_set  in  SET_W  hit set index
- access_way  in  WAY_W  hit way
- victim_req  in  1  miss: allocate a way in victim_set
- victim_set  in  SET_W  miss set index
- flush_valid  in  1  invalidate flush_set
- flush_set  in  SET_W  set to invalidate
- victim_valid  out  1  one-cycle pulse: victim_way/victim_err are valid
- victim_way  out  WAY_W  allocated way
- victim_err  out  1  victim_req carried set index ≥ SETS
- set_full  out  1  combinational: all ways of victim_set valid

## Operation
- Per set: tree[WAYS-1] (node n has children 2n+1 and 2n+2; bit 0 = LRU side is left, 1 = right) and valid[WAYS].
- Touch(way): every node on the root-to-leaf path is set to point away from way, i.e. bit = ~(path direction taken toward way).
- Hit (access_valid): Touch(access_way) in access_set. valid is unchanged.
- Miss (victim_req), with the victim computed from the state at the start of the cycle:
  - If any valid bit is 0, victim = lowest-index invalid way.
  - Otherwise, walk from the root following the node bits; the leaf reached is the victim.
  - Then Touch(victim) and set valid[victim].
- Flush: the set's tree is cleared to 0 and valid to 0.
- Same cycle, same set: flush > victim > hit.
  - Flush + victim: the victim is computed on the empty set (way 0). Final state is flushed, plus way 0 valid and touched.
  - Victim + hit: Touch(hit) is applied first, then Touch(victim) overrides shared path nodes. The victim choice still uses the pre-cycle state.
  - Flush + hit: the hit is dropped.
- Different sets in the same cycle: all operations apply independently.
- Out-of-range set index (≥ SETS):
  - Hit or flush: ignored, no state change.
  - victim_req: victim_valid=1, victim_err=1, victim_way=0, no state change.
- Reset values: all trees 0, all valid 0, victim_valid 0, victim_way 0, victim_err 0.

## Timing
- Hit/flush state updates at the first clk edge after the cycle in which they are asserted.
- Victim: victim_req at cycle N gives victim_valid=1 and victim_way in cycle N+1 (registered). The state update is committed at the same edge.
- Back-to-back victim_req every cycle is supported, including to the same set; request N+1 sees N's update.
- victim_valid is a single-cycle pulse per request. No backpressure; the consumer must sample it.
- rst asserted in cycle N: the request of cycle N is dropped; outputs are 0 in cycle N+1.
- set_full is combinational from victim_set and the current valid bits; zero latency.

## Test plan
- Cold fill, WAYS=16, SETS=4: after reset, 16 victim_req to set 2 → victim_way 0,1,…,15 in consecutive N+1 cycles. set_full=1 after the last; set 0 is untouched (set_full=0 for victim_set=0).
- PLRU walk: continuing from the cold fill, victim_req → way 0. Then hit way 0 followed by victim_req → way 8. Then hit way 8 followed by victim_req → way 4.
- Simultaneous: set full, same cycle hit way 0 + victim_req same set → victim_way 0 (pre-cycle state). The next victim_req → way 8.
- Flush collision: set full, flush_set=1 + victim_req set 1 same cycle → victim_way 0. The next victim_req → way 1.
- Error/reset: SETS=3, victim_req set 3 → victim_err=1, victim_way=0, no state change. Then rst during an in-flight victim_req → no victim_valid, and the next victim_req to a filled set returns way 0.
- Parameter sweep WAYS=2,4,32: cold fill returns 0..WAYS-1. After a full fill the victim is 0; after a hit to 0 the victim is WAYS/2.
